axis_rr_arbiter: RTL and testbench
==================================

// Module: axis_rr_arbiter
// PURPOSE
//  Shares one AXI-Stream sink (the host-side TX stream of the AXI-Lite/AXI-Stream bridge) among
//  NUM_REQ stream requesters. Packet-locked round-robin arbitration: a requester keeps the grant
//  until its tlast beat is accepted. Registered output stage; m_axis_tid carries the source index.
// PARAMETERS
//  NUM_REQ  4   number of requesters, >= 2
//  DATA_W   32  tdata width
//  ID_W     $clog2(NUM_REQ) (localparam)  width of grant index / m_axis_tid
// PORTS
//  aclk           in   1               clock
//  aresetn        in   1               synchronous reset, active-low
//  req_mask       in   NUM_REQ         1 = requester eligible for arbitration
//  s_axis_tdata   in   NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
//  s_axis_tvalid  in   NUM_REQ         per-requester valid
//  s_axis_tlast   in   NUM_REQ         per-requester end of packet
//  s_axis_tready  out  NUM_REQ         per-requester ready; at most one bit high
//  m_axis_tdata   out  DATA_W          registered output data
//  m_axis_tvalid  out  1               registered output valid
//  m_axis_tlast   out  1               registered output last
//  m_axis_tid     out  ID_W            index of requester that produced the beat
//  m_axis_tready  in   1               sink ready
//  busy           out  1               1 while in LOCKED
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, rr_ptr=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0,
//   m_axis_tid=0, s_axis_tready=0, busy=0. Reset mid-packet drops the packet and the held beat.
//  FSM (state_t): IDLE, LOCKED.
//   IDLE: eligible = s_axis_tvalid & req_mask. If eligible!=0, grant <= first set bit searching
//    from rr_ptr upward with wrap (rr_ptr has highest priority); state <= LOCKED. s_axis_tready=0.
//   LOCKED: s_axis_tready[grant] = ~m_axis_tvalid | m_axis_tready; all other bits 0.
//    Accept = s_axis_tvalid[grant] & s_axis_tready[grant]. On accept with tlast=1:
//    state <= IDLE, rr_ptr <= (grant==NUM_REQ-1) ? 0 : grant+1.
//  Output register: on accept load tdata/tlast of grant, tid=grant, tvalid<=1. Else if
//   m_axis_tready, tvalid<=0. Simultaneous drain+load gives full throughput (1 beat/cycle).
//   Output data/last/tid hold stable while tvalid=1 and tready=0.
//  Latency: requester tvalid in IDLE -> earliest m_axis_tvalid 2 cycles later (1 arb + 1 reg).
//   One-cycle bubble on the input side between consecutive packets (IDLE cycle).
//  req_mask: sampled only in IDLE; deasserting a bit during LOCKED does not abort the packet.
//  Requester deasserting tvalid mid-packet: grant is held (no timeout); sink sees a gap.
//  Single-beat packet (tlast on first beat): LOCKED for exactly one accept, then IDLE.
//  No eligible requester: remain IDLE, rr_ptr unchanged.
//  busy = (state==LOCKED).
// STRUCTURE
//  Package axis_arb_pkg: typedef enum logic {IDLE, LOCKED} state_t.
//  Sub-module rr_picker #(N): combinational; inputs req[N], ptr[ID_W]; outputs gnt_idx[ID_W],
//   gnt_any. Rotated priority encode. Instantiated once; rest (FSM, output reg) in top.
// TESTING  (NUM_REQ=4, DATA_W=32)
//  Reset: hold aresetn=0 3 cycles with all tvalid=1 -> all outputs 0, s_axis_tready=0.
//  Single req 2 sends 3-beat pkt A0..A2, m_axis_tready=1 -> m_axis shows A0,A1,A2 on consecutive
//   cycles, tid=2, tlast only on A2, first beat 2 cycles after tvalid; rr_ptr becomes 3.
//  All 4 req valid with 2-beat pkts, mask=4'hF, from reset -> grant order 0,1,2,3,0; no
//   interleave of beats within a packet.
//  Backpressure: m_axis_tready=0 for 5 cycles mid-pkt -> exactly one beat held stable,
//   s_axis_tready[grant]=0; release -> no beat lost or duplicated (scoreboard per tid).
//  Mask: req_mask=4'b1011, req 2 valid -> req 2 never granted; clearing bit 1 while req 1 LOCKED
//   -> req 1 packet completes.
//  Reset asserted mid-packet of req 3 -> next cycle m_axis_tvalid=0, state IDLE, rr_ptr=0.

Source files
------------

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types for the AXI-Stream round-robin arbiter.
package axis_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/axis_rr_arbiter_rr_picker.sv
// Rotated priority encoder: picks the first set request at or after ptr, wrapping around.
module rr_picker #(
   parameter  int N    = 4,
   localparam int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] gnt_idx,
   output logic            gnt_any
);

   logic [ID_W-1:0] idx;

   // Walk offsets from farthest to nearest so the candidate closest to ptr is written last and wins.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = ID_W'((int'(ptr) + k) % N);
         if (req[idx]) begin
            gnt_idx = idx;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one AXI-Stream sink among NUM_REQ requesters.
module axis_rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 32,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [NUM_REQ-1:0]        req_mask,
   input  logic [NUM_REQ*DATA_W-1:0] s_axis_tdata,
   input  logic [NUM_REQ-1:0]        s_axis_tvalid,
   input  logic [NUM_REQ-1:0]        s_axis_tlast,
   output logic [NUM_REQ-1:0]        s_axis_tready,
   output logic [DATA_W-1:0]         m_axis_tdata,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   output logic [ID_W-1:0]           m_axis_tid,
   input  logic                      m_axis_tready,
   output logic                      busy
);

   state_t              state;
   logic [ID_W-1:0]     grant;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     pick_idx;
   logic                pick_any;
   logic [NUM_REQ-1:0]  eligible;
   logic [DATA_W-1:0]   grant_data;
   logic                grant_valid;
   logic                grant_last;
   logic                grant_ready;
   logic                accept;

   assign eligible = s_axis_tvalid & req_mask;

   rr_picker #(.N(NUM_REQ)) u_picker (
      .req     (eligible),
      .ptr     (rr_ptr),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   always_comb begin
      grant_data  = '0;
      grant_valid = 1'b0;
      grant_last  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            grant_data  = s_axis_tdata[i*DATA_W +: DATA_W];
            grant_valid = s_axis_tvalid[i];
            grant_last  = s_axis_tlast[i];
         end
      end
   end

   // The output register can take a new beat when empty or draining this cycle.
   assign grant_ready = (state == LOCKED) && (!m_axis_tvalid || m_axis_tready);
   assign accept      = grant_ready && grant_valid;
   assign busy        = (state == LOCKED);

   always_comb begin
      s_axis_tready = '0;
      if (grant_ready) s_axis_tready[grant] = 1'b1;
   end

   always_ff @(posedge aclk) begin
      // NOTE: reset is synchronous and active-low; sequential state uses non-blocking assignments only.
      if (!aresetn) begin
         state         <= IDLE;
         grant         <= '0;
         rr_ptr        <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tid    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  grant <= pick_idx;
                  state <= LOCKED;
               end
            end
            LOCKED: begin
               if (accept && grant_last) begin
                  state  <= IDLE;
                  rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (accept) begin
            m_axis_tdata  <= grant_data;
            m_axis_tlast  <= grant_last;
            m_axis_tid    <= grant;
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: packet-level reference model, per-source scoreboard, scenario tasks.
module tb_axis_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic            aclk = 1'b0;
   logic            aresetn = 1'b0;
   logic [N-1:0]    req_mask = '1;
   logic [N*DW-1:0] s_tdata = '0;
   logic [N-1:0]    s_tvalid = '0;
   logic [N-1:0]    s_tlast = '0;
   logic [N-1:0]    s_tready;
   logic [DW-1:0]   m_tdata;
   logic            m_tvalid;
   logic            m_tlast;
   logic [1:0]      m_tid;
   logic            m_tready = 1'b1;
   logic            busy;

   axis_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .req_mask      (req_mask),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tid    (m_tid),
      .m_axis_tready (m_tready),
      .busy          (busy)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      int            id;
      int            cyc;
   } obs_t;

   beat_t      src_q[N][$];
   beat_t      sb_q[N][$];
   obs_t       out_log[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   bit         mon_en = 1'b0;
   bit         gap_en = 1'b0;
   int         sink_mode = 0;
   logic [N-1:0] last_hs = '0;

   // Reference model: who owns the sink, who has top priority next, and the beat on the output.
   bit            md_locked = 0;
   int            md_owner = 0;
   int            md_prio = 0;
   bit            md_ov = 0;
   logic [DW-1:0] md_od = '0;
   bit            md_ol = 0;
   int            md_oid = 0;

   always @(posedge aclk) begin : model
      bit took;
      int j;
      cyc++;
      if (!aresetn) begin
         md_locked = 0; md_owner = 0; md_prio = 0;
         md_ov = 0; md_od = '0; md_ol = 0; md_oid = 0;
      end else begin
         took = md_locked && (!md_ov || m_tready) && s_tvalid[md_owner];
         if (took) begin
            md_od  = s_tdata[md_owner*DW +: DW];
            md_ol  = s_tlast[md_owner];
            md_oid = md_owner;
            md_ov  = 1;
         end else if (m_tready) begin
            md_ov = 0;
         end
         if (took && s_tlast[md_owner]) begin
            md_locked = 0;
            md_prio   = (md_owner + 1) % N;
         end else if (!md_locked) begin
            for (int k = 0; k < N; k++) begin
               j = (md_prio + k) % N;
               if (!md_locked && s_tvalid[j] && req_mask[j]) begin
                  md_locked = 1;
                  md_owner  = j;
               end
            end
         end
      end
   end

   always @(negedge aclk) begin : monitor
      logic [N-1:0] exp_ready;
      beat_t        exp_beat;
      if (mon_en) begin
         exp_ready = '0;
         if (md_locked && (!md_ov || m_tready)) exp_ready[md_owner] = 1'b1;
         checks++;
         if ({s_tready, m_tvalid, m_tlast, m_tid, m_tdata, busy} !==
             {exp_ready, md_ov, md_ol, 2'(md_oid), md_od, md_locked}) begin
            failures++;
            $display("FAIL model cyc=%0d got ready=%b v=%b l=%b id=%0d d=%h busy=%b exp ready=%b v=%b l=%b id=%0d d=%h busy=%b",
                     cyc, s_tready, m_tvalid, m_tlast, m_tid, m_tdata, busy,
                     exp_ready, md_ov, md_ol, md_oid, md_od, md_locked);
         end
         if (aresetn && m_tvalid && m_tready) begin
            out_log.push_back('{data: m_tdata, last: m_tlast, id: int'(m_tid), cyc: cyc});
            checks++;
            if (sb_q[m_tid].size() == 0) begin
               failures++;
               $display("FAIL scoreboard_extra tid=%0d got d=%h, no beat expected", m_tid, m_tdata);
            end else begin
               exp_beat = sb_q[m_tid].pop_front();
               if (m_tdata !== exp_beat.data || m_tlast !== exp_beat.last) begin
                  failures++;
                  $display("FAIL scoreboard tid=%0d got d=%h l=%b exp d=%h l=%b",
                           m_tid, m_tdata, m_tlast, exp_beat.data, exp_beat.last);
               end
            end
         end
      end
   end

   task automatic push_pkt(input int r, input int len, input logic [DW-1:0] base);
      for (int b = 0; b < len; b++) src_q[r].push_back('{data: base + DW'(b), last: (b == len - 1)});
   endtask

   function automatic int pending();
      int n = 0;
      for (int i = 0; i < N; i++) n += src_q[i].size() + sb_q[i].size();
      return n;
   endfunction

   task automatic drive_inputs();
      bit held;
      for (int i = 0; i < N; i++) begin
         held = s_tvalid[i] && !last_hs[i];
         if (src_q[i].size() > 0 && (held || !gap_en || $urandom_range(0, 3) != 0)) begin
            s_tvalid[i]          = 1'b1;
            s_tdata[i*DW +: DW]  = src_q[i][0].data;
            s_tlast[i]           = src_q[i][0].last;
         end else begin
            s_tvalid[i] = 1'b0;
         end
      end
      case (sink_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = 1'($urandom_range(0, 1));
         default: m_tready = 1'b0;
      endcase
   endtask

   // One clock: drive after the edge, record source handshakes mid-cycle; returns just after the falling edge.
   task automatic cycle();
      @(posedge aclk);
      #1;
      drive_inputs();
      @(negedge aclk);
      #1;
      last_hs = aresetn ? (s_tvalid & s_tready) : '0;
      for (int i = 0; i < N; i++)
         if (last_hs[i]) sb_q[i].push_back(src_q[i].pop_front());
   endtask

   task automatic do_reset(input int n);
      aresetn = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         sb_q[i].delete();
      end
      repeat (n) cycle();
      aresetn = 1'b1;
      last_hs = '0;
      out_log.delete();
   endtask

   task automatic test_reset();
      aresetn  = 1'b0;
      req_mask = '1;
      s_tvalid = '1;
      s_tlast  = '1;
      s_tdata  = {$urandom, $urandom, $urandom, $urandom};
      m_tready = 1'b1;
      repeat (3) begin
         @(posedge aclk);
         #1;
         mon_en = 1'b1;
         @(negedge aclk);
         #1;
         checks++;
         if ({s_tready, m_tvalid, m_tlast, m_tid, m_tdata, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b v=%b l=%b id=%0d d=%h busy=%b exp all zero",
                     s_tready, m_tvalid, m_tlast, m_tid, m_tdata, busy);
         end
      end
      s_tvalid = '0;
      do_reset(2);
   endtask

   task automatic test_single();
      int c_start;
      int budget = 50;
      do_reset(2);
      sink_mode = 0;
      gap_en    = 0;
      push_pkt(2, 3, 32'hA000_0000);
      cycle();
      c_start = cyc;
      while (out_log.size() < 3 && budget > 0) begin
         cycle();
         budget--;
      end
      checks++;
      if (out_log.size() != 3) begin
         failures++;
         $display("FAIL single_count got %0d beats exp 3", out_log.size());
      end else begin
         checks++;
         if (out_log[0].cyc - c_start != 2) begin
            failures++;
            $display("FAIL single_latency got %0d exp 2", out_log[0].cyc - c_start);
         end
         for (int b = 0; b < 3; b++) begin
            checks++;
            if (out_log[b].id != 2 || out_log[b].last !== (b == 2) ||
                out_log[b].data !== 32'hA000_0000 + 32'(b) || out_log[b].cyc != out_log[0].cyc + b) begin
               failures++;
               $display("FAIL single_beat%0d got id=%0d l=%b d=%h cyc=%0d exp id=2 l=%b d=%h cyc=%0d",
                        b, out_log[b].id, out_log[b].last, out_log[b].data, out_log[b].cyc,
                        (b == 2), 32'hA000_0000 + 32'(b), out_log[0].cyc + b);
            end
         end
      end
      cycle();
      checks++;
      if (dut.rr_ptr !== 2'd3) begin
         failures++;
         $display("FAIL single_rr_ptr got %0d exp 3", dut.rr_ptr);
      end
   endtask

   task automatic test_all_four();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int budget = 200;
      do_reset(2);
      req_mask = '1;
      for (int r = 0; r < N; r++) push_pkt(r, 2, 32'hB000_0000 + 32'(r << 8));
      push_pkt(0, 2, 32'hB000_1000);
      while (out_log.size() < 10 && budget > 0) begin
         cycle();
         budget--;
      end
      checks++;
      if (out_log.size() != 10) begin
         failures++;
         $display("FAIL rr_count got %0d beats exp 10", out_log.size());
      end else begin
         for (int p = 0; p < 5; p++) begin
            checks++;
            if (out_log[2*p].id != exp_order[p] || out_log[2*p+1].id != exp_order[p] ||
                out_log[2*p].last !== 1'b0 || out_log[2*p+1].last !== 1'b1) begin
               failures++;
               $display("FAIL rr_pkt%0d got ids=%0d,%0d lasts=%b%b exp id=%0d lasts=01",
                        p, out_log[2*p].id, out_log[2*p+1].id, out_log[2*p].last, out_log[2*p+1].last,
                        exp_order[p]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] held;
      int budget = 50;
      do_reset(2);
      sink_mode = 0;
      push_pkt(1, 4, 32'hC000_0000);
      while (out_log.size() < 1 && budget > 0) begin
         cycle();
         budget--;
      end
      sink_mode = 2;
      held = 32'hC000_0001;
      for (int s = 0; s < 5; s++) begin
         cycle();
         checks++;
         if (m_tvalid !== 1'b1 || m_tdata !== held || m_tid !== 2'd1 || s_tready[1] !== 1'b0) begin
            failures++;
            $display("FAIL stall%0d got v=%b d=%h id=%0d ready1=%b exp v=1 d=%h id=1 ready1=0",
                     s, m_tvalid, m_tdata, m_tid, s_tready[1], held);
         end
      end
      sink_mode = 0;
      budget = 50;
      while (out_log.size() < 4 && budget > 0) begin
         cycle();
         budget--;
      end
      repeat (3) cycle();
      checks++;
      if (out_log.size() != 4 || pending() != 0) begin
         failures++;
         $display("FAIL bp_complete got beats=%0d pending=%0d exp beats=4 pending=0", out_log.size(), pending());
      end
   endtask

   task automatic test_mask();
      int budget = 100;
      int n1 = 0;
      do_reset(2);
      req_mask = 4'b1011;
      push_pkt(2, 2, 32'hD200_0000);
      repeat (20) begin
         cycle();
         checks++;
         if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL masked_req got busy=%b v=%b exp busy=0 v=0", busy, m_tvalid);
         end
      end
      src_q[2].delete();
      push_pkt(1, 4, 32'hD100_0000);
      while (!busy && budget > 0) begin
         cycle();
         budget--;
      end
      req_mask = 4'b1001;
      budget = 100;
      while (out_log.size() < 4 && budget > 0) begin
         cycle();
         budget--;
      end
      for (int b = 0; b < out_log.size(); b++) if (out_log[b].id == 1) n1++;
      checks++;
      if (n1 != 4 || out_log.size() != 4 || out_log[out_log.size()-1].last !== 1'b1) begin
         failures++;
         $display("FAIL mask_locked got req1 beats=%0d total=%0d exp 4 beats ending in tlast", n1, out_log.size());
      end
      req_mask = '1;
   endtask

   task automatic test_reset_mid();
      int budget = 100;
      do_reset(2);
      sink_mode = 0;
      push_pkt(1, 1, 32'hE100_0000);
      push_pkt(3, 8, 32'hE300_0000);
      while (out_log.size() < 3 && budget > 0) begin
         cycle();
         budget--;
      end
      checks++;
      if (out_log.size() != 3 || dut.rr_ptr !== 2'd2 || busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset got beats=%0d rr_ptr=%0d busy=%b exp beats=3 rr_ptr=2 busy=1",
                  out_log.size(), dut.rr_ptr, busy);
      end
      aresetn = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         sb_q[i].delete();
      end
      cycle();
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || dut.rr_ptr !== 2'd0 || s_tready !== '0) begin
         failures++;
         $display("FAIL mid_reset got v=%b busy=%b rr_ptr=%0d ready=%b exp v=0 busy=0 rr_ptr=0 ready=0",
                  m_tvalid, busy, dut.rr_ptr, s_tready);
      end
      aresetn = 1'b1;
      last_hs = '0;
      out_log.delete();
   endtask

   task automatic test_random();
      int r;
      int budget = 1000;
      do_reset(2);
      gap_en    = 1;
      sink_mode = 1;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, N - 1);
            if (src_q[r].size() < 8) push_pkt(r, $urandom_range(1, 4), $urandom);
         end
         if ($urandom_range(0, 49) == 0) req_mask = 4'($urandom);
         cycle();
      end
      req_mask  = '1;
      gap_en    = 0;
      sink_mode = 0;
      while ((pending() != 0 || busy || m_tvalid) && budget > 0) begin
         cycle();
         budget--;
      end
      checks++;
      if (pending() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL random_drain got pending=%0d busy=%b exp pending=0 busy=0", pending(), busy);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_backpressure();
      test_mask();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
